// File: rtl/just_pass_pkg.sv
// Shared constants, channel-index type and parity helper for the just_pass_arb ingress stage.
package just_pass_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_NUM_CH     = 2;
   localparam int DEF_DEPTH      = 4;
   localparam int CNT_W          = 16;

   // Wide enough for the largest supported channel count (8).
   typedef logic [2:0] ch_idx_t;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Even-parity flag: XOR of all bits, data zero-extended to 64 bits.
   function automatic logic parity_f(input logic [63:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/just_pass_fifo.sv
// Single-channel synchronous FIFO: DEPTH entries, head word visible combinationally, no bypass.
module just_pass_fifo
   import just_pass_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DATA_WIDTH-1:0] head_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  push_ok_s, pop_ok_s;

   assign full_o    = (cnt_q == CW'(DEPTH));
   assign empty_o   = (cnt_q == {CW{1'b0}});
   assign head_o    = mem_q[rd_q];
   assign push_ok_s = push_i & ~full_o;
   assign pop_ok_s  = pop_i & ~empty_o;

   // Pointer and occupancy next-state; pointers wrap naturally at 2**AW.
   always_comb begin
      wr_d  = push_ok_s ? wr_q + AW'(1) : wr_q;
      rd_d  = pop_ok_s  ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q;
      case ({push_ok_s, pop_ok_s})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= {AW{1'b0}};
         rd_q  <= {AW{1'b0}};
         cnt_q <= {CW{1'b0}};
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_q] <= data_i;
      end
   end

endmodule

// File: rtl/just_pass_arb.sv
// Multi-channel FIFO ingress with round-robin merge onto one registered output stream.
// Optional per-channel pass counters: define JUST_PASS_ARB_CNT_EN.
module just_pass_arb
   import just_pass_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int DEPTH      = DEF_DEPTH
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CH-1:0]              in_valid,
   output logic [NUM_CH-1:0]              in_ready,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   data_i,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_WIDTH-1:0]          data_o,
   output logic [ch_w(NUM_CH)-1:0]        out_ch_o,
   output logic                           bool_o
`ifdef JUST_PASS_ARB_CNT_EN
  ,output logic [NUM_CH*CNT_W-1:0]        pass_cnt_o
`endif
);

   localparam int CHW = ch_w(NUM_CH);

   logic [NUM_CH-1:0]     full_s, empty_s, push_s, pop_s;
   logic [DATA_WIDTH-1:0] head_s [NUM_CH];
   logic                  stage_free_s, found_s;
   logic [CHW-1:0]        grant_s;

   logic                  valid_q, valid_d, bool_q, bool_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CHW-1:0]        ch_q, ch_d, last_q, last_d;

   assign in_ready     = ~full_s;
   assign push_s       = in_valid & in_ready;
   assign stage_free_s = ~valid_q | out_ready;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
      just_pass_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push_i  (push_s[g]),
         .pop_i   (pop_s[g]),
         .data_i  (data_i[g*DATA_WIDTH +: DATA_WIDTH]),
         .full_o  (full_s[g]),
         .empty_o (empty_s[g]),
         .head_o  (head_s[g])
      );
   end

   // Round-robin pick: lowest non-empty channel above last_q, else lowest non-empty overall.
   always_comb begin
      logic          lo_hit, hi_hit, found_hi;
      logic [CHW-1:0] g_lo, g_hi;
      lo_hit   = 1'b0;
      hi_hit   = 1'b0;
      found_hi = 1'b0;
      found_s  = 1'b0;
      g_lo     = {CHW{1'b0}};
      g_hi     = {CHW{1'b0}};
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         lo_hit   = ~empty_s[c];
         hi_hit   = lo_hit & (c > int'(last_q));
         g_lo     = lo_hit ? CHW'(c) : g_lo;
         g_hi     = hi_hit ? CHW'(c) : g_hi;
         found_s  = found_s | lo_hit;
         found_hi = found_hi | hi_hit;
      end
      grant_s = found_hi ? g_hi : g_lo;
      for (int c = 0; c < NUM_CH; c++) begin
         pop_s[c] = stage_free_s & found_s & (grant_s == CHW'(c));
      end
   end

   // Output stage next-state: load on grant, drop valid when free and idle, hold on stall.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ch_d    = ch_q;
      bool_d  = bool_q;
      last_d  = last_q;
      if (stage_free_s) begin
         if (found_s) begin
            valid_d = 1'b1;
            data_d  = head_s[grant_s];
            ch_d    = grant_s;
            bool_d  = parity_f(64'(head_s[grant_s]));
            last_d  = grant_s;
         end else begin
            valid_d = 1'b0;
            bool_d  = 1'b0;
         end
      end else begin
         valid_d = valid_q;
      end
   end

   // Output register and arbiter history; reset leaves channel 0 with top priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= {DATA_WIDTH{1'b0}};
         ch_q    <= {CHW{1'b0}};
         bool_q  <= 1'b0;
         last_q  <= CHW'(NUM_CH - 1);
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
         bool_q  <= bool_d;
         last_q  <= last_d;
      end
   end

   assign out_valid = valid_q;
   assign data_o    = data_q;
   assign out_ch_o  = ch_q;
   assign bool_o    = bool_q;

`ifdef JUST_PASS_ARB_CNT_EN
   logic [CNT_W-1:0] cnt_q [NUM_CH];

   // Per-channel count of words leaving the output stage; wraps at 2**CNT_W.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (rst) begin
            cnt_q[c] <= {CNT_W{1'b0}};
         end else if (valid_q && out_ready && (ch_q == CHW'(c))) begin
            cnt_q[c] <= cnt_q[c] + CNT_W'(1);
         end else begin
            cnt_q[c] <= cnt_q[c];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
      assign pass_cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
   end
`endif

endmodule

// File: tb/tb_just_pass_arb.sv
// Self-checking bench for just_pass_arb: queue-based reference model plus directed literal checks.
module tb_just_pass_arb;
   import just_pass_pkg::*;

   localparam int DW = 8;
   localparam int NC = 2;
   localparam int DP = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NC-1:0]  in_valid = '0;
   logic [NC-1:0]  in_ready;
   logic [NC*DW-1:0] data_i = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [DW-1:0]  data_o;
   logic [0:0]     out_ch_o;
   logic           bool_o;
`ifdef JUST_PASS_ARB_CNT_EN
   logic [NC*16-1:0] pass_cnt_o;
`endif

   just_pass_arb #(.DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(DP)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .data_i(data_i), .out_valid(out_valid), .out_ready(out_ready),
      .data_o(data_o), .out_ch_o(out_ch_o), .bool_o(bool_o)
`ifdef JUST_PASS_ARB_CNT_EN
     ,.pass_cnt_o(pass_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [DW-1:0] mq [NC][$];
   bit            mvalid = 0;
   logic [DW-1:0] mdata = '0;
   ch_idx_t       mch = '0;
   bit            mbool = 0;
   int            mlast = NC - 1;
   logic [15:0]   mcnt [NC];
   bit            live = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: advance the model with the inputs seen at the edge, then settle.
   task automatic tick();
      bit acc [NC];
      bit found;
      int ch;
      @(posedge clk);
      if (rst) begin
         for (int c = 0; c < NC; c++) begin
            mq[c].delete();
            mcnt[c] = 16'd0;
         end
         mvalid = 0; mdata = '0; mch = '0; mbool = 0; mlast = NC - 1;
      end else begin
         if (mvalid && out_ready) mcnt[mch] = mcnt[mch] + 16'd1;
         for (int c = 0; c < NC; c++) acc[c] = in_valid[c] && (mq[c].size() < DP);
         if (!mvalid || out_ready) begin
            found = 0;
            for (int i = 1; i <= NC; i++) begin
               ch = (mlast + i) % NC;
               if (!found && mq[ch].size() > 0) begin
                  found  = 1;
                  mdata  = mq[ch].pop_front();
                  mch    = ch_idx_t'(ch);
                  mbool  = ^mdata;
                  mvalid = 1;
                  mlast  = ch;
               end
            end
            if (!found) begin
               mvalid = 0;
               mbool  = 0;
            end
         end
         for (int c = 0; c < NC; c++) if (acc[c]) mq[c].push_back(data_i[c*DW +: DW]);
      end
      live = 1;
      #1;
   endtask

   // Compare DUT against model every cycle, on the falling edge.
   always @(negedge clk) begin
      if (live) begin
         logic [NC-1:0] exp_rdy;
         for (int c = 0; c < NC; c++) exp_rdy[c] = (mq[c].size() != DP);
         chk("out_valid", 32'(out_valid), 32'(mvalid));
         chk("data_o", 32'(data_o), 32'(mdata));
         chk("out_ch_o", 32'(out_ch_o), 32'(mch));
         chk("bool_o", 32'(bool_o), 32'(mbool));
         chk("in_ready", 32'(in_ready), 32'(exp_rdy));
`ifdef JUST_PASS_ARB_CNT_EN
         for (int c = 0; c < NC; c++) chk("pass_cnt", 32'(pass_cnt_o[c*16 +: 16]), 32'(mcnt[c]));
`endif
      end
   end

   initial begin
      logic [NC-1:0] acc;
      logic [DW-1:0] d0, d1;
      int nout, nacc, k;

      // Reset with both channels asserting valid
      rst = 1'b1; in_valid = 2'b11; data_i = 16'h5a5a;
      repeat (3) begin
         tick();
         chk("rst_valid", 32'(out_valid), 32'd0);
         chk("rst_data", 32'(data_o), 32'd0);
         chk("rst_bool", 32'(bool_o), 32'd0);
      end
      rst = 1'b0; in_valid = 2'b00;
      chk("rst_in_ready", 32'(in_ready), 32'h3);

      // Single word, latency one cycle
      in_valid = 2'b01; data_i = 16'h00a5; out_ready = 1'b1;
      tick();
      in_valid = 2'b00;
      chk("single_not_yet", 32'(out_valid), 32'd0);
      tick();
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_data", 32'(data_o), 32'ha5);
      chk("single_ch", 32'(out_ch_o), 32'd0);
      chk("single_bool", 32'(bool_o), 32'd0);
      tick();
      chk("single_drop", 32'(out_valid), 32'd0);

      // Fairness from reset: strict alternation, in-channel order preserved
      rst = 1'b1; tick(); rst = 1'b0;
      d0 = 8'h01; d1 = 8'h81; in_valid = 2'b11; data_i = {d1, d0}; out_ready = 1'b1; nout = 0;
      repeat (12) begin
         acc = in_valid & in_ready;
         tick();
         if (acc[0]) d0++;
         if (acc[1]) d1++;
         data_i = {d1, d0};
         if (out_valid && nout < 8) begin
            chk("fair_ch", 32'(out_ch_o), 32'(nout % 2));
            chk("fair_data", 32'(data_o), (nout % 2) ? 32'h81 + 32'(nout / 2) : 32'h01 + 32'(nout / 2));
            nout++;
         end
      end
      chk("fair_count", 32'(nout), 32'd8);

      // Full FIFO under backpressure, then drain
      in_valid = 2'b00; rst = 1'b1; tick(); rst = 1'b0;
      out_ready = 1'b0; d1 = 8'h10; in_valid = 2'b10; data_i = {d1, 8'h00}; nacc = 0;
      repeat (8) begin
         acc = in_valid & in_ready;
         tick();
         if (acc[1]) begin d1++; nacc++; end
         data_i = {d1, 8'h00};
      end
      chk("full_accepted", 32'(nacc), 32'd5);
      chk("full_in_ready1", 32'(in_ready[1]), 32'd0);
      chk("full_hold_data", 32'(data_o), 32'h10);
      chk("full_hold_ch", 32'(out_ch_o), 32'd1);
      in_valid = 2'b00; out_ready = 1'b1; k = 0;
      repeat (7) begin
         if (out_valid) begin
            chk("drain_data", 32'(data_o), 32'h10 + 32'(k));
            k++;
         end
         tick();
      end
      chk("drain_count", 32'(k), 32'd5);

      // Mid-operation reset discards buffered words
      out_ready = 1'b0; in_valid = 2'b01; d0 = 8'h30;
      repeat (3) begin
         data_i = {8'h00, d0};
         tick();
         d0++;
      end
      in_valid = 2'b00; rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      repeat (5) begin
         tick();
         chk("midrst_stale", 32'(out_valid), 32'd0);
      end

      // Randomized traffic with varying backpressure and rare resets
      for (int i = 0; i < 2000; i++) begin
         in_valid  = NC'($urandom_range(0, 3));
         data_i    = (NC*DW)'($urandom);
         out_ready = (i < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         rst       = ($urandom_range(0, 249) == 0);
         tick();
      end
      rst = 1'b0;

`ifdef JUST_PASS_ARB_CNT_EN
      // Counter wrap: 70000 words through channel 0
      in_valid = 2'b00; rst = 1'b1; tick(); rst = 1'b0;
      out_ready = 1'b1; in_valid = 2'b01; nacc = 0;
      while (nacc < 70000) begin
         data_i = {8'h00, 8'(nacc)};
         acc = in_valid & in_ready;
         tick();
         if (acc[0]) nacc++;
      end
      in_valid = 2'b00;
      repeat (4) tick();
      chk("cnt_ch0_wrap", 32'(pass_cnt_o[15:0]), 32'd4464);
      chk("cnt_ch1_zero", 32'(pass_cnt_o[31:16]), 32'd0);
`endif

      in_valid = 2'b00;
      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
